// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the pipelined shifter/rotator:
//   op_e             - 3-bit operation encoding (5..7 are unused/illegal)
//   shift_payload_t  - stage payload {data, cnt, op, err} at the default width;
//                      shift_pipe declares the same layout at its own WIDTH
//   op_is_illegal()  - flags the unused encodings
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int unsigned OP_W      = 3;
    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ROL = 3'd0,
        OP_SLL = 3'd1,
        OP_ROR = 3'd2,
        OP_SRA = 3'd3,
        OP_SRL = 3'd4
    } op_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [DEF_CNT_W-1:0] cnt;
        op_e                  op;
        logic                 err;
    } shift_payload_t;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > OP_SRL);
    endfunction

endpackage

// File: rtl/shift_level.sv
// -----------------------------------------------------------------------------
// shift_level
// One combinational level of the logarithmic shifter: moves the operand by a
// fixed distance DIST when enabled, according to the operation.
// Ports:
//   i_data  in  WIDTH  operand
//   i_en    in  1      apply this level (the matching count bit)
//   i_op    in  op_e   operation; unused encodings pass data through
//   o_data  out WIDTH  result of this level
// -----------------------------------------------------------------------------
module shift_level
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_en,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_sra;
    logic [WIDTH-1:0] w_sign_fill;

    assign w_sll = i_data << DIST;
    assign w_srl = i_data >> DIST;
    // Rotates reuse the plain shifts and OR in the bits that wrapped around.
    assign w_rol = w_sll | (i_data >> (WIDTH - DIST));
    assign w_ror = w_srl | (i_data << (WIDTH - DIST));
    // Top DIST bits set to the sign bit, rest clear.
    assign w_sign_fill = {WIDTH{i_data[WIDTH-1]}} << (WIDTH - DIST);
    assign w_sra = w_srl | w_sign_fill;

    always_comb begin
        o_data = i_data;
        if (i_en) begin
            case (i_op)
                OP_ROL:  o_data = w_rol;
                OP_SLL:  o_data = w_sll;
                OP_ROR:  o_data = w_ror;
                OP_SRA:  o_data = w_sra;
                OP_SRL:  o_data = w_srl;
                default: o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// -----------------------------------------------------------------------------
// shift_pipe
// Pipelined logarithmic shifter/rotator with valid/ready on both sides.
// CNT_W log levels (level k moves by 2^k when in_cnt[k] is set) are spread
// over STAGES register stages; the last stage register is the output register.
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready  request handshake
//   in_data            operand (WIDTH)
//   in_cnt             shift/rotate amount (CNT_W)
//   in_op              operation, op_e encodings; 5..7 pass data, flag error
//   out_valid/out_ready result handshake
//   out_data           result (WIDTH)
//   out_zero           out_data == 0, registered alongside the result
//   out_err            request used an unused op encoding
// -----------------------------------------------------------------------------
module shift_pipe
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CNT_W  = $clog2(WIDTH),
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_cnt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0) || (CNT_W != $clog2(WIDTH)) ||
        (STAGES < 1) || (STAGES > CNT_W)) begin : g_param_check
        $error("shift_pipe: illegal WIDTH/CNT_W/STAGES combination");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] cnt;
        op_e              op;
        logic             err;
    } stage_t;

    stage_t              w_in_pay;
    stage_t              w_stg_in [STAGES];
    stage_t              r_stg    [STAGES];
    logic [STAGES-1:0]   r_vld;
    logic [STAGES-1:0]   w_adv;
    logic [STAGES-1:0]   w_src_vld;
    logic                r_zero;

    assign w_in_pay = '{data: in_data,
                        cnt:  in_cnt,
                        op:   op_e'(in_op),
                        err:  op_is_illegal(in_op)};

    // ------------------------------------------------------------------
    // Log levels. Level k feeds register stage floor(k*STAGES/CNT_W); the
    // first level of a stage reads the previous stage register (or the
    // input port for stage 0), the last level of a stage drives its D input.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < CNT_W; k++) begin : g_lvl
        localparam int unsigned STG   = (k * STAGES) / CNT_W;
        localparam bit          FIRST = (k == 0) ||
                                        ((((k - 1) * STAGES) / CNT_W) != STG);
        localparam bit          LAST  = (k == CNT_W - 1) ||
                                        ((((k + 1) * STAGES) / CNT_W) != STG);

        stage_t           w_in;
        stage_t           w_out;
        logic [WIDTH-1:0] w_shifted;

        if (!FIRST) begin : g_chain
            assign w_in = g_lvl[k-1].w_out;
        end else if (STG == 0) begin : g_port
            assign w_in = w_in_pay;
        end else begin : g_reg
            assign w_in = r_stg[STG-1];
        end

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (2 ** k)
        ) u_level (
            .i_data (w_in.data),
            .i_en   (w_in.cnt[k]),
            .i_op   (w_in.op),
            .o_data (w_shifted)
        );

        assign w_out = '{data: w_shifted, cnt: w_in.cnt, op: w_in.op, err: w_in.err};

        if (LAST) begin : g_stage_d
            assign w_stg_in[STG] = w_out;
        end
    end

    // ------------------------------------------------------------------
    // Handshake: a stage advances when empty or when its successor
    // advances; the last stage advances when empty or out_ready is high.
    // ------------------------------------------------------------------
    if (STAGES == 1) begin : g_src_one
        assign w_src_vld = in_valid;
    end else begin : g_src_many
        assign w_src_vld = {r_vld[STAGES-2:0], in_valid};
    end

    always_comb begin
        w_adv             = '0;
        w_adv[STAGES-1]   = !r_vld[STAGES-1] || out_ready;
        for (int unsigned j = 1; j < STAGES; j++) begin
            w_adv[STAGES-1-j] = !r_vld[STAGES-1-j] || w_adv[STAGES-j];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_zero <= 1'b0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                r_stg[s] <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                if (w_adv[s]) begin
                    r_vld[s] <= w_src_vld[s];
                    // Payload only moves with valid work so a drained stage
                    // keeps its last value instead of toggling on bubbles.
                    if (w_src_vld[s]) begin
                        r_stg[s] <= w_stg_in[s];
                    end
                end
            end
            if (w_adv[STAGES-1] && w_src_vld[STAGES-1]) begin
                r_zero <= (w_stg_in[STAGES-1].data == '0);
            end
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[STAGES-1];
    assign out_data  = r_stg[STAGES-1].data;
    assign out_err   = r_stg[STAGES-1].err;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_cnt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_zero;
    logic        out_err;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned n_fail = 0;

    shift_pipe #(
        .WIDTH  (16),
        .STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single request into an empty pipe with out_ready=1; called one step
    // after a rising edge. Result must appear after exactly one more edge.
    task automatic txn(input logic [2:0] op, input logic [15:0] d, input logic [3:0] c,
                       input logic [15:0] exp_d, input logic exp_z, input logic exp_e,
                       input string tag);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_cnt   = c;
        chk({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_early_valid"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_zero"}, out_zero, exp_z);
        chk({tag, "_err"}, out_err, exp_e);
        tick();
        chk({tag, "_drained"}, out_valid, 0);
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cnt    = '0;
        in_op     = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_zero", out_zero, 0);
        chk("rst_err", out_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", in_ready, 1);
        chk("post_rst_valid", out_valid, 0);

        // Main function
        txn(3'd0, 16'h3E15, 4'd4,  16'hE153, 1'b0, 1'b0, "rol4");
        txn(3'd2, 16'h00EA, 4'd4,  16'hA00E, 1'b0, 1'b0, "ror4");
        txn(3'd1, 16'hFA7B, 4'd8,  16'h7B00, 1'b0, 1'b0, "sll8");
        txn(3'd1, 16'h0018, 4'd12, 16'h8000, 1'b0, 1'b0, "sll12");
        txn(3'd1, 16'h0018, 4'd13, 16'h0000, 1'b1, 1'b0, "sll13");
        txn(3'd3, 16'hFA7B, 4'd4,  16'hFFA7, 1'b0, 1'b0, "sra4");
        txn(3'd4, 16'hFA7B, 4'd4,  16'h0FA7, 1'b0, 1'b0, "srl4");

        // Count zero passes data for every op; 5..7 also flag an error
        for (int unsigned o = 0; o < 8; o++) begin
            txn(3'(o), 16'hFA7B, 4'd0, 16'hFA7B, 1'b0, (o > 4), $sformatf("cnt0_op%0d", o));
        end

        // Maximum counts
        txn(3'd0, 16'h8001, 4'd15, 16'hC000, 1'b0, 1'b0, "rol15");
        txn(3'd2, 16'h8001, 4'd15, 16'h0003, 1'b0, 1'b0, "ror15");
        txn(3'd3, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 1'b0, "sra15");
        txn(3'd4, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0, "srl15");
        txn(3'd3, 16'h7FFF, 4'd15, 16'h0000, 1'b1, 1'b0, "sra15_pos");

        // Back-pressure: four SLL requests of 0x0001 by 1..4
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd1;
        in_data   = 16'h0001;
        in_cnt    = 4'd1;
        chk("bp_ready_a", in_ready, 1);
        tick();
        in_cnt = 4'd2;
        chk("bp_ready_b", in_ready, 1);
        chk("bp_valid_b", out_valid, 0);
        tick();
        in_cnt = 4'd3;
        chk("bp_ready_c", in_ready, 0);
        chk("bp_valid_c", out_valid, 1);
        chk("bp_data_c", out_data, 16'h0002);
        tick();
        chk("bp_hold1_ready", in_ready, 0);
        chk("bp_hold1_valid", out_valid, 1);
        chk("bp_hold1_data", out_data, 16'h0002);
        chk("bp_hold1_zero", out_zero, 0);
        chk("bp_hold1_err", out_err, 0);
        tick();
        chk("bp_hold2_ready", in_ready, 0);
        chk("bp_hold2_data", out_data, 16'h0002);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_cnt = 4'd4;
        chk("bp_out_b_valid", out_valid, 1);
        chk("bp_out_b_data", out_data, 16'h0004);
        chk("bp_full_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp_out_c_valid", out_valid, 1);
        chk("bp_out_c_data", out_data, 16'h0008);
        tick();
        chk("bp_out_d_valid", out_valid, 1);
        chk("bp_out_d_data", out_data, 16'h0010);
        tick();
        chk("bp_empty", out_valid, 0);

        // Illegal op followed by a legal op in the same stream
        in_valid = 1'b1;
        in_op    = 3'd6;
        in_data  = 16'h1234;
        in_cnt   = 4'd5;
        tick();
        in_op   = 3'd0;
        in_data = 16'h0001;
        in_cnt  = 4'd1;
        chk("ill_early_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        chk("ill_valid", out_valid, 1);
        chk("ill_data", out_data, 16'h1234);
        chk("ill_err", out_err, 1);
        chk("ill_zero", out_zero, 0);
        tick();
        chk("next_valid", out_valid, 1);
        chk("next_data", out_data, 16'h0002);
        chk("next_err", out_err, 0);
        tick();
        chk("ill_empty", out_valid, 0);

        // Reset with two requests in flight
        in_valid = 1'b1;
        in_op    = 3'd1;
        in_data  = 16'h0003;
        in_cnt   = 4'd1;
        tick();
        in_data = 16'h0005;
        tick();
        in_valid = 1'b0;
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_data", out_data, 16'h0006);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_zero", out_zero, 0);
        chk("mid_rst_err", out_err, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        chk("mid_no_stale1", out_valid, 0);
        tick();
        chk("mid_no_stale2", out_valid, 0);
        chk("mid_ready", in_ready, 1);
        txn(3'd4, 16'hF000, 4'd12, 16'h000F, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
